// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the input conditioner.
//   repeat_state_t : per-channel auto-repeat FSM states
//   cnt_width()    : counter width able to hold 0..max_val
package input_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    DELAY    = 2'd1,
    REPEAT   = 2'd2
  } repeat_state_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage : input_cond_pkg

// File: rtl/debounce_channel.sv
// One conditioned input: 2-flop synchronizer, optional inversion, saturating
// debounce counter, press/release pulses and (with INPUT_COND_REPEAT_EN
// defined) an auto-repeat FSM that adds pressed pulses while held.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : asynchronous raw pin
//   level      : debounced active-high state (registered)
//   pressed    : one-cycle pulse on accepted press and on each repeat
//   released   : one-cycle pulse on accepted release
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REPEAT_DELAY    = 13500000,
  parameter int unsigned REPEAT_PERIOD   = 2700000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pressed,
  output logic released
);

  localparam int unsigned CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic        INACT   = 1'(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             level_d, pressed_d, released_d;
  logic             s_c;

`ifdef INPUT_COND_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCNT_W  = cnt_width(RPT_MAX);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
  localparam logic [RCNT_W-1:0] RCNT_MAX    = {RCNT_W{1'b1}};

  repeat_state_t     state, state_d;
  logic [RCNT_W-1:0] rcnt, rcnt_d;
`else
  // Repeat timing parameters have no function in this build.
  logic unused_cfg;
  assign unused_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  // Sample after synchronization, normalised to active-high.
  assign s_c = sync2 ^ INACT;

  // State register: synchronizer, debounce, pulses and repeat FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= INACT;
      sync2    <= INACT;
      cnt      <= '0;
      level    <= 1'b0;
      pressed  <= 1'b0;
      released <= 1'b0;
`ifdef INPUT_COND_REPEAT_EN
      state    <= RELEASED;
      rcnt     <= '0;
`endif
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      cnt      <= cnt_d;
      level    <= level_d;
      pressed  <= pressed_d;
      released <= released_d;
`ifdef INPUT_COND_REPEAT_EN
      state    <= state_d;
      rcnt     <= rcnt_d;
`endif
    end
  end

  // Next-state: debounce counter, level toggle, pulses, repeat FSM.
  always_comb begin
    cnt_d      = cnt;
    level_d    = level;
    pressed_d  = 1'b0;
    released_d = 1'b0;
`ifdef INPUT_COND_REPEAT_EN
    state_d    = state;
    rcnt_d     = rcnt;
`endif

    if (s_c == level) begin
      cnt_d = '0;
    end else if (cnt == CNT_LAST) begin
      // Count completes on this edge: accept the new level.
      level_d    = s_c;
      cnt_d      = '0;
      pressed_d  = s_c;
      released_d = ~s_c;
    end else if (cnt != CNT_MAX) begin
      cnt_d = cnt + CNT_W'(1);
    end

`ifdef INPUT_COND_REPEAT_EN
    // A release on the same edge as a due repeat wins; no pulse is emitted.
    unique case (state)
      RELEASED: begin
        if (pressed_d) begin
          state_d = DELAY;
          rcnt_d  = '0;
        end
      end
      DELAY: begin
        if (released_d) begin
          state_d = RELEASED;
        end else if (rcnt == DELAY_LAST) begin
          state_d   = REPEAT;
          rcnt_d    = '0;
          pressed_d = 1'b1;
        end else if (rcnt != RCNT_MAX) begin
          rcnt_d = rcnt + RCNT_W'(1);
        end
      end
      REPEAT: begin
        if (released_d) begin
          state_d = RELEASED;
        end else if (rcnt == PERIOD_LAST) begin
          rcnt_d    = '0;
          pressed_d = 1'b1;
        end else if (rcnt != RCNT_MAX) begin
          rcnt_d = rcnt + RCNT_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
`endif
  end

endmodule : debounce_channel

// File: rtl/input_conditioner.sv
// Multi-channel button/switch conditioner: one debounce_channel per input.
// Auto-repeat is compiled in only when INPUT_COND_REPEAT_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   raw_in     : asynchronous raw pins, CHANNELS wide
//   level      : debounced active-high state per channel
//   pressed    : per-channel press/repeat pulses
//   released   : per-channel release pulses
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned CHANNELS        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REPEAT_DELAY    = 13500000,
  parameter int unsigned REPEAT_PERIOD   = 2700000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released
);

  // Fully independent channels.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (raw_in[i]),
      .level    (level[i]),
      .pressed  (pressed[i]),
      .released (released[i])
    );
  end

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8, ACTIVE_LOW=1, CHANNELS=5.
// Expectations for repeat pulses follow INPUT_COND_REPEAT_EN.
module tb_input_conditioner;

`ifdef INPUT_COND_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [4:0] raw_in;
  logic [4:0] level, pressed, released;

  input_conditioner #(
    .CHANNELS        (5),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_in   (raw_in),
    .level    (level),
    .pressed  (pressed),
    .released (released)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [4:0] raw;
    logic       rst;
    logic [4:0] lvl;
    logic [4:0] pr;
    logic [4:0] rl;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic add(input string tag, input logic [4:0] raw, input logic rst, input int n,
                     input logic [4:0] l, input logic [4:0] p, input logic [4:0] r);
    vec_t v;
    v.tag = tag; v.raw = raw; v.rst = rst; v.lvl = l; v.pr = p; v.rl = r;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string tag, input logic [4:0] el, input logic [4:0] ep,
                       input logic [4:0] er);
    n_vec++;
    if ({level, pressed, released} !== {el, ep, er}) begin
      n_fail++;
      $display("FAIL %s @%0t: got level=%b pressed=%b released=%b, want level=%b pressed=%b released=%b",
               tag, $time, level, pressed, released, el, ep, er);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    raw_in = 5'b11111;

    // Per-cycle vectors: inputs applied, one edge, then outputs compared.
    add("reset",     5'b11111, 1'b0, 2, 5'b00000, 5'b00000, 5'b00000);
    add("idle",      5'b11111, 1'b1, 3, 5'b00000, 5'b00000, 5'b00000);
    add("p2_wait",   5'b11011, 1'b1, 5, 5'b00000, 5'b00000, 5'b00000);
    add("p2_acc",    5'b11011, 1'b1, 1, 5'b00100, 5'b00100, 5'b00000);
    add("p2_hold",   5'b11011, 1'b1, 3, 5'b00100, 5'b00000, 5'b00000);
    add("r2_wait",   5'b11111, 1'b1, 5, 5'b00100, 5'b00000, 5'b00000);
    add("r2_acc",    5'b11111, 1'b1, 1, 5'b00000, 5'b00000, 5'b00100);
    add("idle",      5'b11111, 1'b1, 2, 5'b00000, 5'b00000, 5'b00000);
    add("b0_dip",    5'b11110, 1'b1, 3, 5'b00000, 5'b00000, 5'b00000);
    add("b0_bounce", 5'b11111, 1'b1, 1, 5'b00000, 5'b00000, 5'b00000);
    add("b0_wait",   5'b11110, 1'b1, 5, 5'b00000, 5'b00000, 5'b00000);
    add("b0_acc",    5'b11110, 1'b1, 1, 5'b00001, 5'b00001, 5'b00000);
    add("r0_wait",   5'b11111, 1'b1, 5, 5'b00001, 5'b00000, 5'b00000);
    add("r0_acc",    5'b11111, 1'b1, 1, 5'b00000, 5'b00000, 5'b00001);
    add("idle",      5'b11111, 1'b1, 2, 5'b00000, 5'b00000, 5'b00000);
    add("all_wait",  5'b00000, 1'b1, 5, 5'b00000, 5'b00000, 5'b00000);
    add("all_acc",   5'b00000, 1'b1, 1, 5'b11111, 5'b11111, 5'b00000);
    add("all_rwait", 5'b11111, 1'b1, 5, 5'b11111, 5'b00000, 5'b00000);
    add("all_racc",  5'b11111, 1'b1, 1, 5'b00000, 5'b00000, 5'b11111);
    add("idle",      5'b11111, 1'b1, 2, 5'b00000, 5'b00000, 5'b00000);

    #1;
    foreach (vecs[i]) begin
      raw_in = vecs[i].raw;
      rst_n  = vecs[i].rst;
      step();
      check(vecs[i].tag, vecs[i].lvl, vecs[i].pr, vecs[i].rl);
    end

    // Reset mid-count: ch3 accepted, ch0 at count 2 when reset asserts.
    raw_in = 5'b10111;
    for (int k = 1; k <= 6; k++) step();
    check("rst_pre_level", 5'b01000, 5'b01000, 5'b00000);
    raw_in = 5'b10110;
    for (int k = 1; k <= 4; k++) step();
    rst_n = 1'b0;
    #1;
    check("rst_async", 5'b00000, 5'b00000, 5'b00000);
    step();
    check("rst_held", 5'b00000, 5'b00000, 5'b00000);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k < 6)       check("rst_relwait", 5'b00000, 5'b00000, 5'b00000);
      else if (k == 6) check("rst_relacc",  5'b01001, 5'b01001, 5'b00000);
      else             check("rst_relhold", 5'b01001, 5'b00000, 5'b00000);
    end
    raw_in = 5'b11111;
    for (int k = 1; k <= 6; k++) step();
    check("rst_release", 5'b00000, 5'b00000, 5'b01001);
    step(); step();

    // Hold ch1 for 60 cycles, then release and watch for stray pulses.
    for (int j = 0; j < 72; j++) begin
      int         n;
      logic       l1, p1, r1;
      raw_in = (j < 60) ? 5'b11101 : 5'b11111;
      step();
      n  = j + 1;
      l1 = (n >= 6) && (n < 66);
      p1 = (n == 6) || (REP && (n >= 26) && (n < 66) && (((n - 26) % 8) == 0));
      r1 = (n == 66);
      check("repeat_ch1", {3'b000, l1, 1'b0}, {3'b000, p1, 1'b0}, {3'b000, r1, 1'b0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_input_conditioner
